// File: rtl/vga_frame_sequencer_pkg.sv
// Constants shared by the frame sequencer, its round-robin picker and the VGA timing generator.
package vga_frame_sequencer_pkg;

   localparam logic [10:0] VSYNC_BLANK_POS = 11'h7FF;
   localparam int          V_ACTIVE        = 480;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_GRANT = 2'd2;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vga_rr_picker.sv
// Combinational round-robin search: first set bit of pending at or after ptr, wrapping modulo N_REQ.
module vga_rr_picker
   import vga_frame_sequencer_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int IW    = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] pending,
   input  logic [IW-1:0]    ptr,
   output logic             found,
   output logic [IW-1:0]    idx
);

   logic [IW:0] pos;

   // Walk from the farthest offset down so the nearest set bit after ptr is written last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         pos = {1'b0, ptr} + (IW + 1)'(i);
         if (pos >= (IW + 1)'(N_REQ)) pos = pos - (IW + 1)'(N_REQ);
         if (pending[pos[IW-1:0]]) begin
            found = 1'b1;
            idx   = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/vga_frame_sequencer.sv
// Pixel-tick divider, vertical-blank entry detection and round-robin sharing of the blanking
// window among update requesters. Define VGA_FRAME_SEQ_OVERRUN_COUNT_EN to add overrun_count.
module vga_frame_sequencer
   import vga_frame_sequencer_pkg::*;
#(
   parameter int N_REQ        = 3,
   parameter int CLK_DIV      = 2,
   parameter int WINDOW_TICKS = 32000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [10:0]      Vpos,
   output logic             pix_en,
   output logic             frame_start,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] gnt,
   output logic             busy,
   input  logic             clr_overrun,
   output logic             overrun
`ifdef VGA_FRAME_SEQ_OVERRUN_COUNT_EN
   ,output logic [7:0]      overrun_count
`endif
);

   localparam int IW = idx_width(N_REQ);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [DW-1:0]    div_q, div_d;
   logic             vblank_q, vblank_d;
   logic             frame_start_q, frame_start_d;
   logic [1:0]       state_q, state_d;
   logic [N_REQ-1:0] pending_q, pending_d;
   logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]    base_q, base_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [15:0]      budget_q, budget_d;
   logic             overrun_q, overrun_d;

   logic             tick;
   logic             expiry;
   logic             release_gnt;
   logic             overrun_set;
   logic [N_REQ-1:0] idx_oh;
   logic [N_REQ-1:0] pend_after;
   logic             pick_found;
   logic [IW-1:0]    pick_idx;

   vga_rr_picker #(.N_REQ(N_REQ)) u_picker (
      .pending (pending_q),
      .ptr     (base_q),
      .found   (pick_found),
      .idx     (pick_idx)
   );

   // NOTE: every signal gets a default at the top so no path through the block infers a latch.
   always_comb begin
      tick          = (div_q == DW'(CLK_DIV - 1));
      div_d         = tick ? '0 : div_q + 1'b1;
      vblank_d      = (Vpos == VSYNC_BLANK_POS);
      frame_start_d = vblank_d & ~vblank_q;

      expiry      = (budget_q == 16'(WINDOW_TICKS)) || !vblank_q;
      idx_oh      = N_REQ'(1) << idx_q;
      release_gnt = (state_q == ST_GRANT) && |(idx_oh & (done | ~req));
      pend_after  = release_gnt ? (pending_q & ~idx_oh) : pending_q;

      state_d     = state_q;
      pending_d   = pending_q;
      rr_ptr_d    = rr_ptr_q;
      base_d      = base_q;
      idx_d       = idx_q;
      budget_d    = (tick && state_q != ST_IDLE) ? budget_q + 16'd1 : budget_q;
      overrun_set = 1'b0;

      // The window scans from the pointer value held before this frame's advance.
      if (frame_start_q) begin
         overrun_set = (state_q != ST_IDLE);
         pending_d   = req;
         base_d      = rr_ptr_q;
         rr_ptr_d    = (rr_ptr_q == IW'(N_REQ - 1)) ? '0 : rr_ptr_q + 1'b1;
         budget_d    = '0;
         state_d     = ST_SCAN;
      end else begin
         case (state_q)
            ST_SCAN: begin
               if (expiry) begin
                  overrun_set = |pending_q;
                  state_d     = ST_IDLE;
               end else if (pick_found) begin
                  idx_d   = pick_idx;
                  state_d = ST_GRANT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_GRANT: begin
               pending_d = pend_after;
               if (expiry) begin
                  overrun_set = |pend_after;
                  state_d     = ST_IDLE;
               end else if (release_gnt) begin
                  state_d = ST_SCAN;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      overrun_d = overrun_set ? 1'b1 : (clr_overrun ? 1'b0 : overrun_q);
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q         <= '0;
         vblank_q      <= 1'b1;
         frame_start_q <= 1'b0;
         state_q       <= ST_IDLE;
         pending_q     <= '0;
         rr_ptr_q      <= '0;
         base_q        <= '0;
         idx_q         <= '0;
         budget_q      <= '0;
         overrun_q     <= 1'b0;
      end else begin
         div_q         <= div_d;
         vblank_q      <= vblank_d;
         frame_start_q <= frame_start_d;
         state_q       <= state_d;
         pending_q     <= pending_d;
         rr_ptr_q      <= rr_ptr_d;
         base_q        <= base_d;
         idx_q         <= idx_d;
         budget_q      <= budget_d;
         overrun_q     <= overrun_d;
      end
   end

   assign pix_en      = tick;
   assign frame_start = frame_start_q;
   assign busy        = (state_q != ST_IDLE);
   assign gnt         = (state_q == ST_GRANT) ? idx_oh : '0;
   assign overrun     = overrun_q;

`ifdef VGA_FRAME_SEQ_OVERRUN_COUNT_EN
   logic [7:0] ovr_cnt_q, ovr_cnt_d;

   always_comb begin
      ovr_cnt_d = ovr_cnt_q;
      if (overrun_set && clr_overrun)          ovr_cnt_d = 8'd1;
      else if (clr_overrun)                    ovr_cnt_d = 8'd0;
      else if (overrun_set && ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) ovr_cnt_q <= 8'd0;
      else       ovr_cnt_q <= ovr_cnt_d;
   end

   assign overrun_count = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed bench for vga_frame_sequencer: tick cadence, round-robin grants, overrun and reset cases.
module tb_vga_frame_sequencer;
   import vga_frame_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] Vpos = VSYNC_BLANK_POS;
   logic [2:0]  req = 3'b000;
   logic [2:0]  done = 3'b000;
   logic        clr_overrun = 1'b0;

   logic        pix_en, frame_start, busy, overrun;
   logic [2:0]  gnt;
   logic        pix_en3, frame_start3, busy3, overrun3;
   logic [2:0]  gnt3;
`ifdef VGA_FRAME_SEQ_OVERRUN_COUNT_EN
   logic [7:0]  overrun_count, overrun_count3;
`endif

   int n_vec = 0;
   int n_err = 0;
   int n_hi  = 0;
   logic [5:0] exp_tick2 = 6'b101010;
   logic [5:0] exp_tick3 = 6'b100100;

   always #5 clk = ~clk;

   vga_frame_sequencer #(.N_REQ(3), .CLK_DIV(2), .WINDOW_TICKS(10)) dut (
      .clk         (clk),
      .reset       (reset),
      .Vpos        (Vpos),
      .pix_en      (pix_en),
      .frame_start (frame_start),
      .req         (req),
      .done        (done),
      .gnt         (gnt),
      .busy        (busy),
      .clr_overrun (clr_overrun),
      .overrun     (overrun)
`ifdef VGA_FRAME_SEQ_OVERRUN_COUNT_EN
      ,.overrun_count (overrun_count)
`endif
   );

   vga_frame_sequencer #(.N_REQ(3), .CLK_DIV(3), .WINDOW_TICKS(10)) dut3 (
      .clk         (clk),
      .reset       (reset),
      .Vpos        (Vpos),
      .pix_en      (pix_en3),
      .frame_start (frame_start3),
      .req         (req),
      .done        (done),
      .gnt         (gnt3),
      .busy        (busy3),
      .clr_overrun (clr_overrun),
      .overrun     (overrun3)
`ifdef VGA_FRAME_SEQ_OVERRUN_COUNT_EN
      ,.overrun_count (overrun_count3)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Leaves the bench at the negedge of the frame_start cycle.
   task automatic start_frame(input string tag);
      Vpos = 11'(V_ACTIVE - 1);
      @(negedge clk);
      Vpos = VSYNC_BLANK_POS;
      @(negedge clk);
      check({tag, "_fs"}, 32'(frame_start), 1);
   endtask

   task automatic wait_gnt();
      for (int i = 0; i < 40 && gnt == 3'b000; i++) @(negedge clk);
   endtask

   task automatic serve(input string tag, input logic [2:0] exp);
      wait_gnt();
      check({tag, "_gnt"}, 32'(gnt), 32'(exp));
      done = exp;
      @(negedge clk);
      done = 3'b000;
      check({tag, "_drop"}, 32'(gnt), 0);
   endtask

   task automatic clear_overrun();
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with Vpos already in blanking.
      repeat (3) @(negedge clk);
      check("rst_pix_en", 32'(pix_en), 0);
      check("rst_fs", 32'(frame_start), 0);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst3_state", 32'({frame_start3, gnt3, busy3, overrun3}), 0);
`ifdef VGA_FRAME_SEQ_OVERRUN_COUNT_EN
      check("rst_ovr_cnt", 32'(overrun_count), 0);
      check("rst3_ovr_cnt", 32'(overrun_count3), 0);
`endif

      // Tick cadence; Vpos stays at blanking so no frame_start may appear.
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check("tick_div2", 32'(pix_en), 32'(exp_tick2[i]));
         check("tick_div3", 32'(pix_en3), 32'(exp_tick3[i]));
         check("no_fs_after_rst", 32'(frame_start), 0);
         @(negedge clk);
      end

      // Frame 1: all three requesting, order 0,1,2.
      req = 3'b111;
      start_frame("f1");
      @(negedge clk);
      check("f1_fs_width", 32'(frame_start), 0);
      check("f1_busy_scan", 32'(busy), 1);
      check("f1_gnt_scan", 32'(gnt), 0);
      @(negedge clk);
      check("f1_gnt_latency", 32'(gnt), 1);
      done = 3'b001;
      @(negedge clk);
      done = 3'b000;
      check("f1_g0_drop", 32'(gnt), 0);
      serve("f1_g1", 3'b010);
      serve("f1_g2", 3'b100);
      @(negedge clk);
      check("f1_busy_end", 32'(busy), 0);
      check("f1_overrun", 32'(overrun), 0);

      // Frame 2: pointer advanced, order 1,2,0.
      start_frame("f2");
      serve("f2_a", 3'b010);
      serve("f2_b", 3'b100);
      serve("f2_c", 3'b001);
      @(negedge clk);
      check("f2_busy_end", 32'(busy), 0);

      // Frame 3: requester 0 never finishes; budget of 10 ticks at 2 clks each.
      req = 3'b001;
      start_frame("f3");
      wait_gnt();
      check("f3_gnt", 32'(gnt), 1);
      n_hi = 0;
      for (int i = 0; i < 60 && gnt != 3'b000; i++) begin
         n_hi++;
         @(negedge clk);
      end
      if (n_hi != 19 && n_hi != 20) $display("f3 grant lasted %0d cycles", n_hi);
      check("f3_window_len_ok", 32'(n_hi == 19 || n_hi == 20), 1);
      check("f3_overrun", 32'(overrun), 1);
      check("f3_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      check("f3_sticky", 32'(overrun), 1);
      clear_overrun();
      check("f3_cleared", 32'(overrun), 0);

      // Frame 4: clear held across the expiry edge; the new overrun must win.
      start_frame("f4");
      clr_overrun = 1'b1;
      wait_gnt();
      check("f4_gnt", 32'(gnt), 1);
      for (int i = 0; i < 60 && gnt != 3'b000; i++) @(negedge clk);
      clr_overrun = 1'b0;
      check("f4_set_wins", 32'(overrun), 1);
`ifdef VGA_FRAME_SEQ_OVERRUN_COUNT_EN
      check("f4_cnt_set_clr", 32'(overrun_count), 1);
`endif
      @(negedge clk);
      check("f4_hold", 32'(overrun), 1);
      clear_overrun();
      check("f4_cleared", 32'(overrun), 0);

      // Frame 5: req[1] withdrawn mid-grant, stray done[2] during gnt[0].
      req = 3'b111;
      start_frame("f5");
      wait_gnt();
      check("f5_gnt1", 32'(gnt), 2);
      req = 3'b101;
      @(negedge clk);
      check("f5_req_drop", 32'(gnt), 0);
      serve("f5_g2", 3'b100);
      wait_gnt();
      check("f5_gnt0", 32'(gnt), 1);
      done = 3'b100;
      @(negedge clk);
      done = 3'b000;
      check("f5_done_ignored", 32'(gnt), 1);
      done = 3'b001;
      @(negedge clk);
      done = 3'b000;
      check("f5_g0_drop", 32'(gnt), 0);
      @(negedge clk);
      check("f5_busy_end", 32'(busy), 0);
      @(negedge clk);
      check("f5_once_per_frame", 32'(gnt), 0);
      check("f5_overrun", 32'(overrun), 0);

      // Frame 6: leaving blanking ends the window early.
      req = 3'b001;
      start_frame("f6");
      wait_gnt();
      check("f6_gnt", 32'(gnt), 1);
      Vpos = 11'(V_ACTIVE - 1);
      @(negedge clk);
      check("f6_vb_hold", 32'(gnt), 1);
      @(negedge clk);
      check("f6_vb_expire", 32'(gnt), 0);
      check("f6_overrun", 32'(overrun), 1);
      clear_overrun();

      // Frame 7: reset mid-grant; pointer and edge detector restart.
      req = 3'b111;
      start_frame("f7");
      wait_gnt();
      check("f7_gnt", 32'(gnt), 1);
      reset = 1'b1;
      @(negedge clk);
      check("f7_rst_gnt", 32'(gnt), 0);
      check("f7_rst_busy", 32'(busy), 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("f7_no_fs", 32'(frame_start), 0);
         @(negedge clk);
      end
      start_frame("f8");
      wait_gnt();
      check("f8_rr_reset", 32'(gnt), 1);
      done = 3'b001;
      @(negedge clk);
      done = 3'b000;
      serve("f8_g1", 3'b010);
      serve("f8_g2", 3'b100);

`ifdef VGA_FRAME_SEQ_OVERRUN_COUNT_EN
      // 300 overrun windows saturate the counter at 255.
      req = 3'b001;
      for (int k = 0; k < 300; k++) begin
         start_frame("sat");
         wait_gnt();
         Vpos = 11'(V_ACTIVE - 1);
         repeat (2) @(negedge clk);
      end
      check("cnt_saturated", 32'(overrun_count), 255);
      clear_overrun();
      check("cnt_cleared", 32'(overrun_count), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
